// File: rtl/cubic_pkg.sv
// Shared constants and helpers for the Catmull-Rom cubic interpolation pipeline.
// The pixel-field indices define the in_p packing used throughout the resizer.
package cubic_pkg;

    localparam int unsigned CUBIC_LAT = 4;

    // Field positions of the four neighbours inside one channel of in_p.
    localparam int unsigned PM1 = 0;
    localparam int unsigned P0  = 1;
    localparam int unsigned P1  = 2;
    localparam int unsigned P2  = 3;

    function automatic int unsigned cubic_width(input int unsigned pix_w,
                                                input int unsigned frac_w);
        return pix_w + 3 * frac_w + 6;
    endfunction

endpackage

// File: rtl/cubic_lane.sv
// Per-channel Catmull-Rom datapath: four enable-gated stages evaluating the cubic in Horner form.
// Every intermediate is held at a signed width that cannot overflow for the given PIX_W/FRAC_W.
module cubic_lane
    import cubic_pkg::*;
#(
    parameter int unsigned PIX_W  = 8,
    parameter int unsigned FRAC_W = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               en_i,
    input  logic [FRAC_W-1:0]  t_i,
    input  logic [4*PIX_W-1:0] p_i,
    output logic [PIX_W-1:0]   val_o
);

    localparam int unsigned W = cubic_width(PIX_W, FRAC_W);
    localparam int unsigned F = FRAC_W;

    typedef logic signed [W-1:0] acc_t;

    localparam acc_t Half   = acc_t'({{(W-1){1'b0}}, 1'b1} << (3 * F));
    localparam acc_t PixMax = acc_t'({{(W-PIX_W){1'b0}}, {PIX_W{1'b1}}});

    function automatic acc_t ext_pix(input logic [PIX_W-1:0] x);
        return acc_t'({{(W-PIX_W){1'b0}}, x});
    endfunction

    function automatic acc_t ext_t(input logic [FRAC_W-1:0] x);
        return acc_t'({{(W-FRAC_W){1'b0}}, x});
    endfunction

    acc_t pm1, p0, p1, p2, t0;
    acc_t c1_d, c2_d, c3_d, a_d, b_d, r, q;
    logic [PIX_W-1:0] val_d;

    acc_t c1_1_q, c2_1_q, c3_1_q, p0_1_q, t_1_q;
    acc_t a_2_q, c1_2_q, p0_2_q, t_2_q;
    acc_t b_3_q, p0_3_q, t_3_q;
    logic [PIX_W-1:0] val_q;

    always_comb begin
        pm1 = ext_pix(p_i[PM1*PIX_W +: PIX_W]);
        p0  = ext_pix(p_i[P0*PIX_W +: PIX_W]);
        p1  = ext_pix(p_i[P1*PIX_W +: PIX_W]);
        p2  = ext_pix(p_i[P2*PIX_W +: PIX_W]);
        t0  = ext_t(t_i);

        // Coefficients are twice the textbook Catmull-Rom ones; the final shift removes the 2.
        c1_d = p1 - pm1;
        c2_d = (pm1 <<< 1) - ((p0 <<< 2) + p0) + (p1 <<< 2) - p2;
        c3_d = ((p0 <<< 1) + p0) - ((p1 <<< 1) + p1) + p2 - pm1;

        a_d = (c2_1_q <<< F) + t_1_q * c3_1_q;
        b_d = (c1_2_q <<< (2 * F)) + t_2_q * a_2_q;
        r   = (p0_3_q <<< (3 * F + 1)) + t_3_q * b_3_q;
        q   = (r + Half) >>> (3 * F + 1);

        if (q[W-1]) begin
            val_d = '0;
        end else if (q > PixMax) begin
            val_d = '1;
        end else begin
            val_d = q[PIX_W-1:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (en_i) begin
            c1_1_q <= c1_d;
            c2_1_q <= c2_d;
            c3_1_q <= c3_d;
            p0_1_q <= p0;
            t_1_q  <= t0;
            a_2_q  <= a_d;
            c1_2_q <= c1_1_q;
            p0_2_q <= p0_1_q;
            t_2_q  <= t_1_q;
            b_3_q  <= b_d;
            p0_3_q <= p0_2_q;
            t_3_q  <= t_2_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            val_q <= '0;
        end else if (en_i) begin
            val_q <= val_d;
        end
    end

    assign val_o = val_q;

endmodule

// File: rtl/cubic_interp_pipe.sv
// Fully pipelined multi-channel Catmull-Rom interpolator with valid/ready backpressure.
// A single advance enable moves all stages together; stalls freeze the whole pipe.
module cubic_interp_pipe
    import cubic_pkg::*;
#(
    parameter int unsigned PIX_W  = 8,
    parameter int unsigned FRAC_W = 8,
    parameter int unsigned CH     = 1
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [FRAC_W-1:0]       in_t,
    input  logic [4*CH*PIX_W-1:0]   in_p,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [CH*PIX_W-1:0]     out_val
);

    logic [CUBIC_LAT-1:0] v_q, v_d;
    logic                 en;

    always_comb begin
        en  = !v_q[CUBIC_LAT-1] || out_ready;
        v_d = v_q;
        if (en) begin
            v_d = {v_q[CUBIC_LAT-2:0], in_valid};
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            v_q <= '0;
        end else begin
            v_q <= v_d;
        end
    end

    assign in_ready  = en;
    assign out_valid = v_q[CUBIC_LAT-1];

    for (genvar c = 0; c < CH; c++) begin : g_lane
        cubic_lane #(
            .PIX_W  (PIX_W),
            .FRAC_W (FRAC_W)
        ) u_lane (
            .clk_i (CLK),
            .rst_i (RST),
            .en_i  (en),
            .t_i   (in_t),
            .p_i   (in_p[c*4*PIX_W +: 4*PIX_W]),
            .val_o (out_val[c*PIX_W +: PIX_W])
        );
    end

endmodule

// File: tb/tb_cubic_interp_pipe.sv
// Self-checking bench: three configurations of the interpolator against a polynomial reference.
// Latency is counted in clock edges, with the transfer edge as the first.
module tb_cubic_interp_pipe;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    int checks = 0;
    int errs   = 0;
    int cyc    = 0;

    // Configuration A: PIX_W=8, FRAC_W=8, CH=1
    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [7:0]  a_in_t, a_out_val;
    logic [31:0] a_in_p;
    // Configuration B: PIX_W=8, FRAC_W=8, CH=3
    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [7:0]  b_in_t;
    logic [95:0] b_in_p;
    logic [23:0] b_out_val;
    // Configuration C: PIX_W=10, FRAC_W=6, CH=1
    logic        c_in_valid, c_in_ready, c_out_valid, c_out_ready;
    logic [5:0]  c_in_t;
    logic [39:0] c_in_p;
    logic [9:0]  c_out_val;

    cubic_interp_pipe #(.PIX_W(8), .FRAC_W(8), .CH(1)) u_a (
        .CLK(CLK), .RST(RST), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_t(a_in_t),
        .in_p(a_in_p), .out_valid(a_out_valid), .out_ready(a_out_ready), .out_val(a_out_val)
    );
    cubic_interp_pipe #(.PIX_W(8), .FRAC_W(8), .CH(3)) u_b (
        .CLK(CLK), .RST(RST), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_t(b_in_t),
        .in_p(b_in_p), .out_valid(b_out_valid), .out_ready(b_out_ready), .out_val(b_out_val)
    );
    cubic_interp_pipe #(.PIX_W(10), .FRAC_W(6), .CH(1)) u_c (
        .CLK(CLK), .RST(RST), .in_valid(c_in_valid), .in_ready(c_in_ready), .in_t(c_in_t),
        .in_p(c_in_p), .out_valid(c_out_valid), .out_ready(c_out_ready), .out_val(c_out_val)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Catmull-Rom as an expanded polynomial in t (scaled by 2), rounded half up, clamped.
    function automatic longint model(input int pw, input int fw, input longint pm1,
                                     input longint p0, input longint p1, input longint p2,
                                     input longint t);
        longint c1, c2, c3, r, q, mx;
        c1 = p1 - pm1;
        c2 = 2 * pm1 - 5 * p0 + 4 * p1 - p2;
        c3 = -pm1 + 3 * p0 - 3 * p1 + p2;
        r  = p0 * (longint'(1) << (3 * fw + 1)) + c1 * t * (longint'(1) << (2 * fw))
           + c2 * t * t * (longint'(1) << fw) + c3 * t * t * t;
        q  = (r + (longint'(1) << (3 * fw))) >>> (3 * fw + 1);
        mx = (longint'(1) << pw) - 1;
        if (q < 0) return 0;
        if (q > mx) return mx;
        return q;
    endfunction

    function automatic logic [23:0] b_model(input logic [95:0] p, input logic [7:0] t);
        logic [23:0] res;
        for (int ch = 0; ch < 3; ch++) begin
            res[ch*8 +: 8] = 8'(model(8, 8, longint'(p[ch*32 +: 8]), longint'(p[ch*32+8 +: 8]),
                                      longint'(p[ch*32+16 +: 8]), longint'(p[ch*32+24 +: 8]),
                                      longint'(t)));
        end
        return res;
    endfunction

    longint      a_q[$];
    logic [23:0] b_q[$];
    longint      c_q[$];
    int a_nin, a_nout, a_first_in, a_first_out, a_last_out;

    task automatic a_tick();
        logic       stall;
        logic [7:0] held;
        longint     e;
        #1;
        if (a_out_valid && a_out_ready) begin
            e = (a_q.size() > 0) ? a_q.pop_front() : -1;
            check("a_stream", 64'(a_out_val), e);
            if (a_nout == 0) a_first_out = cyc;
            a_last_out = cyc;
            a_nout++;
        end
        stall = a_out_valid && !a_out_ready;
        held  = a_out_val;
        if (stall) check("a_stall_ready", 64'(a_in_ready), 64'(0));
        if (a_in_valid && a_in_ready) begin
            a_q.push_back(model(8, 8, longint'(a_in_p[7:0]), longint'(a_in_p[15:8]),
                                longint'(a_in_p[23:16]), longint'(a_in_p[31:24]),
                                longint'(a_in_t)));
            if (a_nin == 0) a_first_in = cyc;
            a_nin++;
        end
        @(posedge CLK); #1; cyc++;
        if (stall) check("a_stall_hold", {55'd0, a_out_valid, a_out_val}, {55'd0, 1'b1, held});
    endtask

    task automatic a_single(input string tag, input logic [31:0] p, input logic [7:0] t,
                            input logic [7:0] exp);
        int n;
        a_in_p = p; a_in_t = t; a_in_valid = 1'b1; a_out_ready = 1'b1;
        #1;
        check({tag, "_rdy"}, 64'(a_in_ready), 64'(1));
        @(posedge CLK); #1;
        a_in_valid = 1'b0;
        n = 1;
        while (!a_out_valid && n < 12) begin
            @(posedge CLK); #1; n++;
        end
        check({tag, "_lat"}, 64'(n), 64'(4));
        check({tag, "_val"}, 64'(a_out_val), 64'(exp));
        @(posedge CLK); #1;
    endtask

    task automatic b_tick();
        logic [23:0] e;
        #1;
        if (b_out_valid && b_out_ready) begin
            e = (b_q.size() > 0) ? b_q.pop_front() : 24'hxxxxxx;
            check("b_stream", 64'(b_out_val), 64'(e));
        end
        if (b_in_valid && b_in_ready) b_q.push_back(b_model(b_in_p, b_in_t));
        @(posedge CLK); #1;
    endtask

    task automatic c_tick();
        longint e;
        #1;
        if (c_out_valid && c_out_ready) begin
            e = (c_q.size() > 0) ? c_q.pop_front() : -1;
            check("c_stream", 64'(c_out_val), e);
        end
        if (c_in_valid && c_in_ready) begin
            c_q.push_back(model(10, 6, longint'(c_in_p[9:0]), longint'(c_in_p[19:10]),
                                longint'(c_in_p[29:20]), longint'(c_in_p[39:30]),
                                longint'(c_in_t)));
        end
        @(posedge CLK); #1;
    endtask

    initial begin
        int stale, n;
        RST = 1'b1;
        a_in_valid = 0; a_out_ready = 1; a_in_t = '0; a_in_p = '0;
        b_in_valid = 0; b_out_ready = 1; b_in_t = '0; b_in_p = '0;
        c_in_valid = 0; c_out_ready = 1; c_in_t = '0; c_in_p = '0;
        a_nin = 0; a_nout = 0; a_first_in = 0; a_first_out = 0; a_last_out = 0;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        check("rst_valid", 64'(a_out_valid), 64'(0));
        check("rst_val", 64'(a_out_val), 64'(0));
        check("rst_ready", 64'(a_in_ready), 64'(1));

        // Reset with three beats in flight
        for (int i = 0; i < 3; i++) begin
            a_in_valid = 1'b1; a_in_p = $urandom(); a_in_t = 8'($urandom());
            @(posedge CLK); #1;
        end
        a_in_valid = 1'b0; RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        check("mid_rst_valid", 64'(a_out_valid), 64'(0));
        check("mid_rst_val", 64'(a_out_val), 64'(0));
        check("mid_rst_ready", 64'(a_in_ready), 64'(1));
        stale = 0;
        repeat (8) begin
            @(posedge CLK); #1;
            stale += int'(a_out_valid);
        end
        check("mid_rst_stale", 64'(stale), 64'(0));

        // Directed values; fields packed {P2,P1,P0,Pm1}
        a_single("midpoint", {8'd255, 8'd255, 8'd0, 8'd0}, 8'h80, 8'd128);
        a_single("t_zero", {8'd200, 8'd9, 8'd42, 8'd7}, 8'h00, 8'd42);
        a_single("clamp_hi", {8'd0, 8'd255, 8'd255, 8'd0}, 8'h80, 8'd255);
        a_single("clamp_lo", {8'd255, 8'd0, 8'd0, 8'd255}, 8'h80, 8'd0);
        a_single("const_t00", {4{8'd100}}, 8'h00, 8'd100);
        a_single("const_t40", {4{8'd100}}, 8'h40, 8'd100);
        a_single("const_tff", {4{8'd100}}, 8'hFF, 8'd100);

        // Random stream with pseudo-random backpressure
        a_nin = 0; a_nout = 0;
        for (int i = 0; i < 400 && (a_nin < 17 || a_q.size() > 0); i++) begin
            a_out_ready = 1'($urandom_range(0, 1));
            a_in_valid  = (a_nin < 17) && ($urandom_range(0, 3) != 0);
            a_in_p = $urandom(); a_in_t = 8'($urandom());
            a_tick();
        end
        check("bp_in_count", 64'(a_nin), 64'(17));
        check("bp_out_count", 64'(a_nout), 64'(17));
        check("bp_sb_empty", 64'(a_q.size()), 64'(0));

        // Full-rate streaming with out_ready held high
        a_in_valid = 1'b0; a_out_ready = 1'b1;
        repeat (6) a_tick();
        a_nin = 0; a_nout = 0;
        for (int i = 0; i < 8; i++) begin
            a_in_valid = 1'b1; a_in_p = $urandom(); a_in_t = 8'($urandom());
            #1;
            check("tp_ready", 64'(a_in_ready), 64'(1));
            a_tick();
        end
        a_in_valid = 1'b0;
        for (int i = 0; i < 20 && a_q.size() > 0; i++) a_tick();
        check("tp_out_count", 64'(a_nout), 64'(8));
        check("tp_first_lat", 64'(a_first_out - a_first_in), 64'(4));
        check("tp_back_to_back", 64'(a_last_out - a_first_out), 64'(7));

        // Multichannel directed and random
        b_in_p = {8'd0, 8'd255, 8'd255, 8'd0, {4{8'd100}}, 8'd255, 8'd255, 8'd0, 8'd0};
        b_in_t = 8'h80; b_in_valid = 1'b1;
        @(posedge CLK); #1;
        b_in_valid = 1'b0;
        n = 1;
        while (!b_out_valid && n < 12) begin
            @(posedge CLK); #1; n++;
        end
        check("mc_lat", 64'(n), 64'(4));
        check("mc_val", 64'(b_out_val), 64'(24'hFF6480));
        @(posedge CLK); #1;
        for (int i = 0; i < 6; i++) begin
            b_in_valid = 1'b1; b_in_p = {$urandom(), $urandom(), $urandom()};
            b_in_t = 8'($urandom());
            b_tick();
        end
        b_in_valid = 1'b0;
        for (int i = 0; i < 12 && b_q.size() > 0; i++) b_tick();
        check("mc_sb_empty", 64'(b_q.size()), 64'(0));

        // PIX_W=10, FRAC_W=6 sweep
        for (int i = 0; i < 20; i++) begin
            c_in_valid = 1'b1; c_in_p = {8'($urandom()), $urandom()};
            c_in_t = 6'($urandom());
            c_tick();
        end
        c_in_valid = 1'b0;
        for (int i = 0; i < 12 && c_q.size() > 0; i++) c_tick();
        check("sw_sb_empty", 64'(c_q.size()), 64'(0));
        c_in_p = {10'd1023, 10'd1023, 10'd0, 10'd0}; c_in_t = 6'd32; c_in_valid = 1'b1;
        @(posedge CLK); #1;
        c_in_valid = 1'b0;
        n = 1;
        while (!c_out_valid && n < 12) begin
            @(posedge CLK); #1; n++;
        end
        check("sw_mid_lat", 64'(n), 64'(4));
        check("sw_mid_val", 64'(c_out_val), 64'(512));

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/cubic_interp_pipe.md
Name: cubic_interp_pipe

Overview:
- Parametrised, fully pipelined successor to the 5-cycle serial Catmull-Rom cubic unit used by the image resizer.
- Accepts all four neighbour pixels P(-1), P(0), P(1), P(2) plus a fractional phase t in one beat, for CH independent colour channels.
- Sustains one result per cycle with valid/ready backpressure; feeds the resizer's horizontal and vertical passes.

Parameters:
- PIX_W, 8: pixel bits per channel (unsigned).
- FRAC_W, 8: phase bits; t = in_t / 2^FRAC_W, range [0, 1).
- CH, 1: channel count; all channels share in_t.

Ports:
- CLK, input, 1: clock; all logic on rising edge.
- RST, input, 1: synchronous, active-high reset.
- in_valid, input, 1: input beat valid.
- in_ready, output, 1: block can accept a beat this cycle.
- in_t, input, FRAC_W: phase for the beat.
- in_p, input, 4*CH*PIX_W: pixels. Channel c occupies bits [c*4*PIX_W +: 4*PIX_W]. Within a channel, PIX_W-wide fields at index 0..3 are P(-1), P(0), P(1), P(2).
- out_valid, output, 1: result valid.
- out_ready, input, 1: downstream accepts.
- out_val, output, CH*PIX_W: interpolated pixels; channel c at [c*PIX_W +: PIX_W].

Behaviour:
- Reset: all stage valid bits cleared; out_valid=0; out_val=0. in_ready=1 in the first cycle after reset. A reset mid-stream drops every in-flight beat.
- Pipeline: 4 register stages (S1..S4) with one global advance enable, en = !out_valid || out_ready. in_ready = en.
- A beat transfers on in_valid && in_ready. With out_ready held high, latency is exactly 4 cycles from the transfer edge to out_valid high, and throughput is 1 beat per cycle.
- Stall: when out_valid && !out_ready, every stage and out_val hold; no beat is lost or duplicated. Bubbles (valid=0) propagate normally.
- Arithmetic is per channel, signed, computed at internal width PIX_W+3*FRAC_W+6 (no overflow possible). F = FRAC_W.
- S1 coefficients, scaled by 2:
  - c1 = P1 - Pm1
  - c2 = 2Pm1 - 5P0 + 4P1 - P2
  - c3 = -Pm1 + 3P0 - 3P1 + P2
  - also register P0 and t.
- S2: a = (c2 << F) + t*c3
- S3: b = (c1 << 2F) + t*a
- S4: r = (P0 << (3F+1)) + t*b
- Output: q = (r + 2^(3F)) >>> (3F+1), i.e. round half up via arithmetic shift. Clamp q to [0, 2^PIX_W - 1] and register as out_val.
- Exactness: t=0 gives P0 exactly. Constant inputs give that constant for every t.

Decomposition:
- Shared package cubic_pkg holds:
  - the stage count CUBIC_LAT=4;
  - a function computing internal width from PIX_W/FRAC_W;
  - the pixel-field index constants (PM1=0, P0=1, P1=2, P2=3) used by in_p packing across the resizer.
- One sub-module, cubic_lane: the per-channel S1..S4 datapath, taking the enable and t. It is instantiated CH times by generate. Valid bits and handshake stay in cubic_interp_pipe.

Test Plan:
1. Reset: assert RST mid-stream with 3 beats in flight -> next cycle out_valid=0, out_val=0, in_ready=1; no stale beat emerges later.
2. Midpoint (PIX_W=8, FRAC_W=8, CH=1): P=(0,0,255,255), t=0x80 -> out_val=128 exactly 4 cycles after the transfer edge. Then P=(7,42,9,200), t=0 -> 42.
3. Clamping: P=(0,255,255,0), t=0x80 -> 255 (raw 286.9). P=(255,0,0,255), t=0x80 -> 0 (raw -31.9). Constant 100 at t=0x00, 0x40, 0xFF -> 100 each.
4. Throughput/backpressure: stream 17 random beats with out_ready toggling pseudo-randomly -> output sequence matches a golden model in order, with no drops or duplicates. With out_ready=1, one result per cycle after the 4-cycle fill. While stalled, out_val stays stable and in_ready=0.
5. Multichannel (CH=3): per-channel P sets (0,0,255,255), (100,100,100,100), (0,255,255,0) at t=0x80 -> out_val={255,100,128} (channel 2 in the top byte).
6. Parameter sweep (PIX_W=10, FRAC_W=6): random vectors vs reference model -> bit-exact match. P=(0,0,1023,1023), t=32 -> 512.
